// File: rtl/scan_led_rx.sv
// Receiver for a scanned 8-digit LED stream: resynchronizes scan/seg, tracks digit order,
// and publishes complete frames on a0..a7. Optional error counter: SCAN_RX_ERRCNT_EN.
//
//   state   | meaning
//   HUNT    | waiting for digit 0 to start a frame; other legal digits ignored
//   CAPTURE | filling the shadow buffer; exp is the next digit index expected
module scan_led_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan,
  input  logic [3:0] seg,
  output logic [3:0] a0,
  output logic [3:0] a1,
  output logic [3:0] a2,
  output logic [3:0] a3,
  output logic [3:0] a4,
  output logic [3:0] a5,
  output logic [3:0] a6,
  output logic [3:0] a7,
  output logic       frame_valid,
`ifdef SCAN_RX_ERRCNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic       err
);

  typedef enum logic {HUNT, CAPTURE} state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] scan_s1;
  logic [7:0] scan_s2;
  logic [3:0] seg_s1;
  logic [3:0] seg_s2;

  logic [2:0] idx;
  logic       legal;

  logic [2:0] exp;
  logic [2:0] exp_nxt;
  logic [2:0] exp_m1;
  logic       hit_exp;
  logic       hit_held;
  logic       hit_zero;

  logic       wr_en;
  logic       commit;
  logic       err_set;

  logic [3:0] shadow [8];
  logic [3:0] disp   [8];

  // scan and seg travel together so the FSM always sees a coherent pair
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_s1 <= '0;
      scan_s2 <= '0;
      seg_s1  <= '0;
      seg_s2  <= '0;
    end else begin
      scan_s1 <= scan;
      scan_s2 <= scan_s1;
      seg_s1  <= seg;
      seg_s2  <= seg_s1;
    end
  end

  always_comb begin
    idx   = 3'd0;
    legal = 1'b1;
    case (scan_s2)
      8'b1000_0000: idx = 3'd0;
      8'b0100_0000: idx = 3'd1;
      8'b0010_0000: idx = 3'd2;
      8'b0001_0000: idx = 3'd3;
      8'b0000_1000: idx = 3'd4;
      8'b0000_0100: idx = 3'd5;
      8'b0000_0010: idx = 3'd6;
      8'b0000_0001: idx = 3'd7;
      default:      legal = 1'b0;
    endcase
  end

  assign exp_m1   = exp - 3'd1;
  assign hit_exp  = legal && (idx == exp);
  assign hit_held = legal && (idx == exp_m1);
  assign hit_zero = legal && (idx == 3'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: begin
        if (hit_zero) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (hit_exp) begin
          if (exp == 3'd7) state_nxt = HUNT;
        end else if (hit_held || hit_zero) begin
          state_nxt = CAPTURE;
        end else begin
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // held-digit match is tested before the digit-0 restart so a repeated digit 0 is benign
  always_comb begin
    wr_en   = 1'b0;
    commit  = 1'b0;
    err_set = 1'b0;
    exp_nxt = exp;
    case (state)
      HUNT: begin
        exp_nxt = 3'd0;
        if (hit_zero) begin
          wr_en   = 1'b1;
          exp_nxt = 3'd1;
        end else if (!legal) begin
          err_set = 1'b1;
        end
      end
      CAPTURE: begin
        if (hit_exp) begin
          if (exp == 3'd7) begin
            commit  = 1'b1;
            exp_nxt = 3'd0;
          end else begin
            wr_en   = 1'b1;
            exp_nxt = exp + 3'd1;
          end
        end else if (hit_held) begin
          wr_en = 1'b1;
        end else if (hit_zero) begin
          err_set = 1'b1;
          wr_en   = 1'b1;
          exp_nxt = 3'd1;
        end else begin
          err_set = 1'b1;
          exp_nxt = 3'd0;
        end
      end
      default: exp_nxt = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp         <= 3'd0;
      shadow      <= '{default: '0};
      disp        <= '{default: '0};
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      exp         <= exp_nxt;
      frame_valid <= commit;
      err         <= err_set;
      if (wr_en) shadow[idx] <= seg_s2;
      // digit 7 comes straight from the synchronizer so the frame lands in one edge
      if (commit) begin
        for (int i = 0; i < 7; i++) disp[i] <= shadow[i];
        disp[7] <= seg_s2;
      end
    end
  end

  assign a0 = disp[0];
  assign a1 = disp[1];
  assign a2 = disp[2];
  assign a3 = disp[3];
  assign a4 = disp[4];
  assign a5 = disp[5];
  assign a6 = disp[6];
  assign a7 = disp[7];

`ifdef SCAN_RX_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/scan_led_rx.md
SCAN_LED_RX -- requirements
Module: scan_led_rx

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low, sampled on posedge clk.
REQ-003 SHALL have port scan, input, 8 bits: one-hot digit select from the scanning driver; 8'b10000000 = digit 0 ... 8'b00000001 = digit 7.
REQ-004 SHALL have port seg, input, 4 bits: digit value accompanying scan.
REQ-005 SHALL have ports a0..a7, output, 4 bits each: last complete captured frame, digit 0..7.
REQ-006 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when a0..a7 are updated.
REQ-007 SHALL have port err, output, 1 bit: one-cycle pulse on a protocol violation.
REQ-008 SHALL have port err_cnt, output, 8 bits, present only when SCAN_RX_ERRCNT_EN is defined.

Function
REQ-009 SHALL pass scan and seg together through a 2-stage register synchronizer; the FSM acts only on stage-2 values.
REQ-010 SHALL decode the stage-2 scan to index 0..7 when exactly one bit is set; any other value (zero or multiple bits) SHALL be flagged illegal.
REQ-011 SHALL implement FSM states HUNT and CAPTURE, plus an expected-index register exp[2:0] and an 8x4 shadow buffer.
REQ-012 In HUNT: index 0 -> write seg to shadow[0], set exp=1, go to CAPTURE; any other legal index -> stay in HUNT with no error; illegal -> err pulse, stay in HUNT.
REQ-013 In CAPTURE: an index equal to exp -> write shadow[exp]; if exp==7, commit; otherwise exp increments by 1.
REQ-014 In CAPTURE: an index equal to exp-1 (held digit) -> overwrite that shadow entry; no advance, no error.
REQ-015 In CAPTURE: any other legal index -> err pulse, go to HUNT. Exception: index 0 -> err pulse, restart capture, writing shadow[0] and setting exp=1.
REQ-016 In CAPTURE: an illegal scan value -> err pulse, go to HUNT, shadow discarded.
REQ-017 Commit SHALL copy shadow[0..6] plus the current seg (digit 7) into a0..a7 atomically, pulse frame_valid for 1 cycle, and return to HUNT.
REQ-018 Latency: frame_valid SHALL assert on the 3rd posedge clk after the edge at which digit 7 is first present at the inputs; a0..a7 update on that same edge.
REQ-019 a0..a7 SHALL hold their values between commits; partial or aborted frames never reach the outputs.
REQ-020 The transmitter advancing one digit per clk SHALL yield one frame_valid every 8 cycles in steady state.
REQ-021 When frame_valid and err would occur in the same cycle, both SHALL be asserted.

Reset
REQ-022 While rst_n=0 at posedge clk: FSM->HUNT, exp=0, synchronizer stages and shadow cleared to 0, a0..a7=0, frame_valid=0, err=0, err_cnt=0.
REQ-023 Reset mid-frame SHALL discard the partial frame; capture resumes at the first digit 0 seen after release (after synchronizer latency).

Configuration
REQ-024 With SCAN_RX_ERRCNT_EN defined: port err_cnt SHALL exist, increment on each err pulse, and saturate at 8'hFF. Without it: no err_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-025 Digits 1,2,...,8 sent in order, one per clk -> frame_valid 3 clks after digit 7; a0..a7=1..8; err=0.
REQ-026 Start the stream mid-frame at digit 5 -> no err; the first frame_valid follows the first complete 0..7 sequence.
REQ-027 Send digit 3 after digit 1 (digit 2 skipped) -> one err pulse; outputs unchanged; the next full frame captures correctly.
REQ-028 Apply scan=8'b11000000 during CAPTURE -> err pulse, no frame_valid for that frame; with the macro defined, err_cnt increments to 1.
REQ-029 Hold each digit for 2 clks, values A..H -> frame_valid every 16 clks, a0..a7=A..H, err=0.
REQ-030 Assert rst_n=0 for 1 clk after digit 4 -> all outputs 0; a later full frame of 9s -> a0..a7=9, single frame_valid.
